// File: rtl/seg_scan_controller_if.sv
// -----------------------------------------------------------------------------
// seg_scan_controller_if
//   IO-bus side of the display controller: a one-cycle write strobe carrying a
//   14-bit binary value, plus the status the CPU can read back.
//
//   wr_en    master -> slave  write strobe (one-cycle pulse)
//   wr_data  master -> slave  unsigned binary value to display
//   busy     slave -> master  conversion in progress; writes are dropped
//   ovf      slave -> master  last accepted value was > 9999
// -----------------------------------------------------------------------------
interface seg_scan_controller_if;
    logic        wr_en;
    logic [13:0] wr_data;
    logic        busy;
    logic        ovf;

    modport master (output wr_en, wr_data, input  busy, ovf);
    modport slave  (input  wr_en, wr_data, output busy, ovf);
endinterface

// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//   Converts a written 14-bit binary value to four BCD digits with a
//   sequential shift-add-3 (double-dabble) engine, holds the result, and
//   time-multiplexes one seven-segment decoder across four digit positions.
//
//   Ports
//     clock      system clock, rising edge
//     reset      synchronous, active-high
//     bus        seg_scan_controller_if.slave (wr_en, wr_data, busy, ovf)
//     digit_sel  one-hot digit enable, bit0 = ones ... bit3 = thousands
//     HEX        segment pattern, active-high, bit6 = a ... bit0 = g
//
//   Parameters
//     SCAN_DIV        cycles each digit stays selected (>= 1)
//     SEL_ACTIVE_LOW  1 inverts digit_sel at the output register
//
//   Build option
//     LEADING_ZERO_BLANK_EN  blank zero digits above the most significant
//                            non-zero digit when loading a new value
// -----------------------------------------------------------------------------
module seven_segment_decoder (
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        case (code)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;  // 10-15 dark; 4'hF is the blank code
        endcase
    end
endmodule

module seg_scan_controller #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    seg_scan_controller_if.slave  bus,
    output logic [3:0]            digit_sel,
    output logic [6:0]            HEX
);
    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    state_t      state, state_next;
    logic        accept;
    logic [13:0] bin_q;         // binary value being shifted out
    logic [15:0] acc_q;         // BCD accumulator, four nibbles
    logic [15:0] acc_adj;       // accumulator after the add-3 step
    logic [3:0]  iter_q;        // remaining double-dabble iterations
    logic        ovf_pend_q;
    logic        ovf_q;
    logic [15:0] disp_q;        // digits currently on display
    logic [15:0] load_digits;
    logic [PW-1:0] presc_q;
    logic [1:0]  idx_q;
    logic [6:0]  seg_dec;

    // ---------------- control FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (bus.wr_en) begin
                accept     = 1'b1;
                state_next = CONV;
            end
            CONV: if (iter_q == 4'd1) state_next = LOAD;
            LOAD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.ovf  = ovf_q;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // Digits as they will be latched into the display in LOAD.
    always_comb begin
        load_digits = acc_q;
`ifdef LEADING_ZERO_BLANK_EN
        if (acc_q[15:12] == 4'd0) begin
            load_digits[15:12] = 4'hF;
            if (acc_q[11:8] == 4'd0) begin
                load_digits[11:8] = 4'hF;
                if (acc_q[7:4] == 4'd0) load_digits[7:4] = 4'hF;
            end
        end
`endif
    end

    // ---------------- conversion datapath ----------------
    // NOTE: the display registers are explicitly reset so an aborted
    // conversion leaves a defined all-zero display rather than stale digits.
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_q      <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bin_q      <= bus.wr_data;
                    acc_q      <= '0;
                    iter_q     <= 4'd14;
                    ovf_pend_q <= (bus.wr_data > 14'd9999);
                end
                CONV: begin
                    {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
                    iter_q         <= iter_q - 4'd1;
                end
                LOAD: begin
                    disp_q <= ovf_pend_q ? 16'hFFFF : load_digits;
                    ovf_q  <= ovf_pend_q;
                end
                default: ;
            endcase
        end
    end

    // ---------------- scan ----------------
    // Free-running prescaler, independent of the conversion FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    seven_segment_decoder u_dec (
        .code (disp_q[{idx_q, 2'b00} +: 4]),
        .seg  (seg_dec)
    );

    // Select and pattern register on the same edge so they always agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_sel <= {4{SEL_ACTIVE_LOW}};
            HEX       <= '0;
        end else begin
            digit_sel <= (4'b0001 << idx_q) ^ {4{SEL_ACTIVE_LOW}};
            HEX       <= seg_dec;
        end
    end
endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Display controller for the IO subsystem of the single-cycle computer.
- Accepts a 14-bit binary value from an IO write, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and holds the result.
- Time-multiplexes one shared seven_segment_decoder instance across four digit positions, driving a one-hot digit select plus the decoded segment pattern.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays selected; legal range >= 1.
- SEL_ACTIVE_LOW, 0: 1 inverts digit_sel at the output register.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe from the IO bus; one-cycle pulse.
- wr_data  in  14  unsigned binary value to display.
- busy  out  1  conversion in progress; writes are ignored while high.
- ovf  out  1  last accepted value was > 9999.
- digit_sel  out  4  one-hot digit enable; bit0 = ones digit, bit3 = thousands digit.
- HEX  out  7  segment pattern, active-high, bit6 = a ... bit0 = g.

Behaviour:
- Reset values (next edge with reset = 1):
  - busy = 0, ovf = 0, digit_sel = 0 (all off; all on if SEL_ACTIVE_LOW), HEX = 7'b0000000.
  - Display BCD registers = 0, scan index = 0, prescaler = 0, FSM = IDLE.
- FSM states: IDLE, CONV, LOAD.
  - IDLE: wr_en = 1 is accepted at that edge.
    - wr_data is captured into the shift register; the BCD accumulator is cleared; the iteration count is set to 14.
    - ovf_pending is set to (wr_data > 9999).
    - Next state is CONV.
  - CONV: one iteration per cycle.
    - Each BCD nibble >= 5 gets +3.
    - Then {bcd, bin} shifts left by 1.
    - After the 14th iteration, go to LOAD.
  - LOAD: display registers <= accumulator, or 4'hF in every digit if ovf_pending.
    - ovf <= ovf_pending.
    - Next state is IDLE.
- busy = (state != IDLE).
- Latency: accept edge at cycle 0.
  - busy is high in cycles 1..15.
  - The new digits and the new ovf are visible from cycle 16.
  - A new write can be accepted in cycle 16.
- Boundary conditions:
  - wr_en while busy is dropped silently; nothing is queued and the display is unchanged.
  - wr_en in the same cycle as reset: reset wins.
  - Reset during CONV or LOAD aborts the conversion; the display is cleared to 0.
  - Old digits stay displayed throughout a conversion, so no partial values ever appear.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count the scan index advances 0->1->2->3->0 (wrap) and the prescaler reloads 0.
  - SCAN_DIV = 1 advances every cycle.
- Output registers:
  - digit_sel <= onehot(index).
  - HEX <= decoder(display[index]).
  - Both are registered on the same edge, so they always refer to the same digit, with one cycle of latency after the index changes.
  - The first cycle after reset release shows digit_sel = 4'b0001 and HEX = 7'b1111110.
- Decoder mapping:
  - Codes 0-9 map to the standard patterns (e.g. 4 = 7'b0110011).
  - Codes 10-15 give 7'b0000000; 4'hF is used as the blank code.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in LOAD, zero digits above the most significant non-zero digit are replaced by 4'hF (blank). Digit0 is never blanked, so a value of 0 shows a single "0". Overflow blanking is unchanged.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan (bench uses SCAN_DIV = 4):
- Reset held 3 cycles then released -> busy = 0, ovf = 0; first cycle after release digit_sel = 0001, HEX = 1111110; digit_sel = 0010 appears 4 cycles later.
- Write 1234 -> busy high exactly cycles 1..15. From cycle 16 the scan shows:
  - digit0 = 4 (0110011)
  - digit1 = 3 (1111001)
  - digit2 = 2 (1101101)
  - digit3 = 1 (0110000)
  - ovf = 0.
- Write 9999 -> all digits 1111011, ovf = 0. Then write 10000 -> all HEX = 0000000, ovf = 1. Then write 0 -> ovf returns to 0.
- Write 1234, then pulse wr_en with 5678 at cycle 5 -> second write ignored; display shows 1234; busy falls after cycle 15.
- Write 8888, assert reset at cycle 7 -> busy = 0 next cycle; display reads 0000; ovf = 0; no 8 ever appears.
- With LEADING_ZERO_BLANK_EN, write 7:
  - digits 3..1 HEX = 0000000, digit0 = 1110000.
  - Write 0 -> digit0 = 1111110, others blank.
  - Without the macro, write 7 shows 0,0,0,7.
